// File: rtl/axis_seq_divider.sv
// Radix-2 restoring divider behind the operand/result streams.
// Returns {quotient, remainder}; tuser flags divide-by-zero.
module axis_seq_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tuser
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] tdata_q, tdata_d;
  logic               tuser_q, tuser_d;

  logic               hs;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign hs = rst_n & (state_q == IDLE)
            & s_axis_divisor_tvalid
            & s_axis_dividend_tvalid;

  assign s_axis_divisor_tready  = hs;
  assign s_axis_dividend_tready = hs;

  assign sa = SIGNED & s_axis_dividend_tdata[WIDTH-1];
  assign sb = SIGNED & s_axis_divisor_tdata[WIDTH-1];

  // Negating -2^(W-1) wraps to itself, which is its correct unsigned magnitude
  assign abs_a = sa ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign abs_b = sb ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

  assign shl   = {rem_q, quo_q[WIDTH-1]};
  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          dvd_d   = s_axis_dividend_tdata;
          dvs_d   = abs_b;
          quo_d   = abs_a;
          rem_d   = '0;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          zero_d  = (s_axis_divisor_tdata == '0);
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        if (shl >= {1'b0, dvs_q}) begin
          rem_d = WIDTH'(shl - {1'b0, dvs_q});
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shl[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          tdata_d = {{WIDTH{1'b1}}, dvd_q};
          tuser_d = 1'b1;
        end else begin
          tdata_d = {q_fix, r_fix};
          tuser_d = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        if (m_axis_dout_tready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      tdata_q <= '0;
      tuser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
    end
  end

  assign m_axis_dout_tvalid = (state_q == OUT);
  assign m_axis_dout_tdata  = tdata_q;
  assign m_axis_dout_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_seq_divider.sv
// Bench for axis_seq_divider: unsigned (u0) and signed (u1) builds
// checked against vector tables, corner sequences and an arithmetic model.
module tb_axis_seq_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           dvs_v[2], dvd_v[2], m_rdy[2];
  logic           dvs_r[2], dvd_r[2], o_v[2], o_u[2];
  logic [W-1:0]   dvs_d[2], dvd_d[2];
  logic [2*W-1:0] o_d[2];

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_divisor_tvalid(dvs_v[0]),
    .s_axis_divisor_tready(dvs_r[0]),
    .s_axis_divisor_tdata(dvs_d[0]),
    .s_axis_dividend_tvalid(dvd_v[0]),
    .s_axis_dividend_tready(dvd_r[0]),
    .s_axis_dividend_tdata(dvd_d[0]),
    .m_axis_dout_tvalid(o_v[0]),
    .m_axis_dout_tready(m_rdy[0]),
    .m_axis_dout_tdata(o_d[0]),
    .m_axis_dout_tuser(o_u[0])
  );

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_divisor_tvalid(dvs_v[1]),
    .s_axis_divisor_tready(dvs_r[1]),
    .s_axis_divisor_tdata(dvs_d[1]),
    .s_axis_dividend_tvalid(dvd_v[1]),
    .s_axis_dividend_tready(dvd_r[1]),
    .s_axis_dividend_tdata(dvd_d[1]),
    .m_axis_dout_tvalid(o_v[1]),
    .m_axis_dout_tready(m_rdy[1]),
    .m_axis_dout_tdata(o_d[1]),
    .m_axis_dout_tuser(o_u[1])
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {tuser, quotient, remainder} from plain arithmetic
  function automatic logic [64:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {1'b0, q[31:0], r[31:0]};
    end
    return {1'b0, a / b, a % b};
  endfunction

  task automatic hs(int id, string nm);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (dvs_r[id] && dvd_r[id]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, " handshake"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    dvs_v[id] = 1'b0;
    dvd_v[id] = 1'b0;
  endtask

  // Called right after the handshake edge; consumer samples tvalid one edge later
  task automatic collect(int id, string nm, logic [64:0] exp);
    int lat = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (o_v[id]) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, " seen"}, 64'(seen), 64'd1);
    chk({nm, " latency"}, 64'(lat + 1), 64'(W + 2));
    chk({nm, " tdata"}, o_d[id], exp[63:0]);
    chk({nm, " tuser"}, 64'(o_u[id]), 64'(exp[64]));
    if (m_rdy[id]) begin
      @(posedge clk);
      #1;
      chk({nm, " drop"}, 64'(o_v[id]), 64'd0);
    end
  endtask

  task automatic xfer(int id, logic [31:0] a, logic [31:0] b,
                      string nm, logic [64:0] exp);
    @(negedge clk);
    dvd_d[id] = a;
    dvs_d[id] = b;
    dvd_v[id] = 1'b1;
    dvs_v[id] = 1'b1;
    m_rdy[id] = 1'b1;
    hs(id, nm);
    collect(id, nm, exp);
  endtask

  typedef struct {
    int          id;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [63:0] exp;
    bit          usr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [63:0] held;
    int cnt;
    for (int i = 0; i < 2; i++) begin
      dvs_v[i] = 1'b1;
      dvd_v[i] = 1'b1;
      m_rdy[i] = 1'b1;
      dvs_d[i] = '0;
      dvd_d[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset tready", {62'd0, dvs_r[i], dvd_r[i]}, 64'd0);
      chk("reset tvalid", 64'(o_v[i]), 64'd0);
      chk("reset tdata", o_d[i], 64'd0);
      chk("reset tuser", 64'(o_u[i]), 64'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dvs_v[i] = 1'b0;
      dvd_v[i] = 1'b0;
    end
    rst_n = 1'b1;

    tbl[0] = '{0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b0};
    tbl[1] = '{1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0};
    tbl[2] = '{1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1}, 1'b0};
    tbl[3] = '{1, 32'h1234_5678, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678}, 1'b1};
    tbl[4] = '{0, 32'h1234_5678, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678}, 1'b1};
    tbl[5] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1'b0};
    tbl[6] = '{0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0};
    tbl[7] = '{0, 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0}, 1'b0};
    tbl[8] = '{1, 32'h8000_0000, 32'd1, {32'h8000_0000, 32'd0}, 1'b0};

    foreach (tbl[i])
      xfer(tbl[i].id, tbl[i].dvd, tbl[i].dvs, $sformatf("vec%0d", i),
           {tbl[i].usr, tbl[i].exp});

    // Lone divisor valid must not be consumed
    @(negedge clk);
    dvs_d[1] = 32'd40;
    dvd_d[1] = 32'hFFFF_FF9C;
    dvs_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lone tready", {62'd0, dvs_r[1], dvd_r[1]}, 64'd0);
      @(negedge clk);
    end
    dvd_v[1] = 1'b1;
    #1;
    chk("pair tready", {62'd0, dvs_r[1], dvd_r[1]}, 64'd3);
    @(posedge clk);
    #1;
    chk("pair tready once", {62'd0, dvs_r[1], dvd_r[1]}, 64'd0);
    dvs_v[1] = 1'b0;
    dvd_v[1] = 1'b0;
    collect(1, "lone", {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFEC});

    // Backpressure: result held, next pair waits
    @(negedge clk);
    m_rdy[0] = 1'b0;
    dvd_d[0] = 32'd1000;
    dvs_d[0] = 32'd33;
    dvd_v[0] = 1'b1;
    dvs_v[0] = 1'b1;
    hs(0, "bp");
    collect(0, "bp", {1'b0, 32'd30, 32'd10});
    held = o_d[0];
    dvd_d[0] = 32'd77;
    dvs_d[0] = 32'd5;
    dvd_v[0] = 1'b1;
    dvs_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp tvalid", 64'(o_v[0]), 64'd1);
      chk("bp tdata", o_d[0], held);
      chk("bp tready", {62'd0, dvs_r[0], dvd_r[0]}, 64'd0);
    end
    @(negedge clk);
    m_rdy[0] = 1'b1;
    #1;
    chk("bp out tready", {62'd0, dvs_r[0], dvd_r[0]}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp released", 64'(o_v[0]), 64'd0);
    chk("bp next tready", {62'd0, dvs_r[0], dvd_r[0]}, 64'd3);
    hs(0, "bp2");
    collect(0, "bp2", {1'b0, 32'd15, 32'd2});

    // Reset ten cycles into CALC
    @(negedge clk);
    dvd_d[0] = 32'hFFFF_FFFF;
    dvs_d[0] = 32'd3;
    dvd_v[0] = 1'b1;
    dvs_v[0] = 1'b1;
    hs(0, "rst");
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    dvd_v[0] = 1'b1;
    dvs_v[0] = 1'b1;
    #1;
    chk("rst tready", {62'd0, dvs_r[0], dvd_r[0]}, 64'd0);
    chk("rst tvalid", 64'(o_v[0]), 64'd0);
    dvd_v[0] = 1'b0;
    dvs_v[0] = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (o_v[0]) cnt++;
    end
    chk("rst no result", 64'(cnt), 64'd0);
    xfer(0, 32'd50, 32'd5, "post rst", {1'b0, 32'd10, 32'd0});

    // Randomized against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      int id;
      logic [31:0] a, b;
      id = i % 2;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 20));
        1: b = -32'($urandom_range(1, 5));
        2: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      xfer(id, a, b, $sformatf("rnd%0d", i), model(id == 1, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_seq_divider.md
Name: axis_seq_divider

Overview:
- Synthesizable iterative integer divider that is the responder on the operand/result stream interface the core's Div wrapper drives.
- Same channel set and data packing as the existing divider IP, so it drops in behind Div without changes to Div.
- Accepts a divisor/dividend pair, runs a radix-2 restoring division one quotient bit per cycle, and returns {quotient, remainder} on the dout stream.
- Follows RISC-V DIV/REM rules for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand width in bits; dout is 2*WIDTH bits.
- SIGNED, 1, 1 = two's-complement division (DIV/REM); 0 = unsigned (DIVU/REMU).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_divisor_tready  output  1  divisor ready.
- s_axis_divisor_tdata  input  WIDTH  divisor.
- s_axis_dividend_tvalid  input  1  dividend valid.
- s_axis_dividend_tready  output  1  dividend ready.
- s_axis_dividend_tdata  input  WIDTH  dividend.
- m_axis_dout_tvalid  output  1  result valid.
- m_axis_dout_tready  input  1  result accepted by consumer.
- m_axis_dout_tdata  output  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.
- m_axis_dout_tuser  output  1  1 = divide-by-zero occurred for this result.

Behaviour:
- Reset: rst_n sampled low at a clk edge puts the FSM in IDLE. Both s tready signals = 0, m_axis_dout_tvalid = 0, tdata = 0, tuser = 0, iteration counter = 0.
- Reset mid-operation aborts the division with no result emitted. Reset while OUT drops tvalid at that edge.
- Both s tready signals are identical: tready = (state==IDLE) & divisor_tvalid & dividend_tvalid.
  - Both channels therefore handshake in the same cycle.
  - A lone valid is never consumed; it waits for its partner.
- FSM states:
  - IDLE: waits for the joint handshake. On the handshake edge it latches the operands, records signs, takes absolute values (SIGNED=1), clears the partial remainder, loads the count to WIDTH, and moves to CALC.
  - CALC: one restoring step per cycle. Shift {rem, quo} left 1. If rem >= |divisor|, subtract and set the quotient LSB. Decrement the count. Move to FIX after WIDTH cycles.
  - FIX: applies signs and special cases, then registers tdata and tuser and moves to OUT.
  - OUT: tvalid = 1, and tdata/tuser are stable while tvalid=1 & tready=0. On tvalid & tready the FSM moves to IDLE and tvalid drops the next cycle.
- Latency: handshake at edge N gives tvalid = 1 at edge N+WIDTH+2 (34 for WIDTH=32).
  - Latency is fixed for every case, including special cases.
  - Maximum throughput is one result per WIDTH+3 cycles when tready is held high.
- Arithmetic, SIGNED=1:
  - Quotient truncates toward zero.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are computed unsigned on WIDTH bits, with an internal WIDTH+1-bit compare/subtract.
  - |−2^(W−1)| is represented correctly as an unsigned value.
- Divide-by-zero (divisor==0): quotient = all ones, remainder = dividend, tuser = 1. Applies to both signed and unsigned modes.
- Signed overflow (dividend = −2^(W−1), divisor = −1): quotient = −2^(W−1), remainder = 0, tuser = 0.
- SIGNED=0: no sign handling; everything else is identical.
- The core's Div wrapper uses only tdata[2W-1:W]. The remainder is provided for REM/REMU.

Test Plan:
- Unsigned basic (SIGNED=0): dividend 100, divisor 7, tready=1 → tvalid exactly 34 cycles after the handshake, tdata = {32'd14, 32'd2}, tuser=0, tvalid high one cycle.
- Signed mixed signs: dividend −7 (0xFFFFFFF9), divisor 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also dividend 7, divisor −2 → {0xFFFFFFFD, 0x00000001}.
- Divide-by-zero: dividend 0x12345678, divisor 0 → {0xFFFFFFFF, 0x12345678}, tuser=1, in both SIGNED=1 and SIGNED=0 builds.
- Signed overflow: dividend 0x80000000, divisor 0xFFFFFFFF → {0x80000000, 0x00000000}, tuser=0.
- Handshake and backpressure:
  - Only divisor_tvalid high for 5 cycles → both treadys stay 0 and no transfer occurs.
  - Raise dividend_tvalid → both treadys high for exactly one cycle.
  - Hold m tready=0 for 10 cycles after the result → tvalid/tdata stable, s treadys stay 0.
  - Release tready → result transferred; the next pair is accepted no earlier than the following cycle.
- Reset mid-operation: assert rst_n=0 for one cycle 10 cycles into CALC → no result ever emitted, treadys 0 during reset. A new pair 50/5 afterwards → {10, 0} with the full 34-cycle latency.
